fetch_sequencer: RTL

// Controls the fetch stage of the pipelined LEGv8 core. Owns the PC, issues

---
 rtl/fetch_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC and runs the req/ack handshake with the
// instruction memory, applying branch redirects, hazard stalls and a timeout trap.
module fetch_sequencer #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   PC_RESET = '0,
  parameter int             TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_M,
  input  logic [N-1:0] PCBranch_M,
  input  logic         stall_F,
  input  logic         imem_ack,
  output logic         imem_req,
  output logic [N-1:0] imem_addr_F,
  output logic         instr_valid_F,
  output logic         flush_F,
  output logic         timeout_err,
  output logic [31:0]  fetch_count
);

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   WAIT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STALL,
    S_REDIRECT,
    S_ERROR
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wait;
  logic [N-1:0]  r_pc;
  logic          r_valid;
  logic          r_flush;
  logic          r_err;
  logic [31:0]   r_count;

  // Branch targets are word aligned; the low two bits are masked rather than sliced off.
  logic [N-1:0] w_target;
  logic [N-1:0] w_pc_next;

  assign w_target  = PCBranch_M & ~N'(3);
  assign w_pc_next = r_pc + N'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_pc    <= PC_RESET;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_wait  <= '0;
        end
        S_REQ: begin
          if (PCSrc_M) begin
            r_pc    <= w_target;
            r_flush <= 1'b1;
            r_wait  <= '0;
            r_state <= S_REDIRECT;
          end else if (imem_ack) begin
            r_wait <= '0;
            if (stall_F) begin
              r_state <= S_STALL;
            end else begin
              r_pc    <= w_pc_next;
              r_valid <= 1'b1;
              r_count <= r_count + 32'd1;
            end
          end else if (r_wait == WAIT_MAX) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        S_STALL: begin
          if (PCSrc_M) begin
            r_pc    <= w_target;
            r_flush <= 1'b1;
            r_wait  <= '0;
            r_state <= S_REDIRECT;
          end else if (!stall_F) begin
            r_wait  <= '0;
            r_state <= S_REQ;
          end
        end
        S_REDIRECT: begin
          r_wait  <= '0;
          r_state <= S_REQ;
        end
        S_ERROR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req      = (r_state == S_REQ);
  assign imem_addr_F   = r_pc;
  assign instr_valid_F = r_valid;
  assign flush_F       = r_flush;
  assign timeout_err   = r_err;
  assign fetch_count   = r_count;

endmodule
